// File: rtl/div_pkg.sv
// Shared types and defaults for the sequential restoring divider.
package div_pkg;

  typedef enum logic {StIdle, StCalc} div_state_e;

  localparam int unsigned DIV_WA = 16;
  localparam int unsigned DIV_WB = 8;

  function automatic int unsigned div_cnt_w(int unsigned wa);
    return $clog2(wa + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in a dividend bit, trial subtract.
module div_step import div_pkg::*; #(
  parameter int unsigned WB = DIV_WB
) (
  input  logic [WB:0]   r_i,
  input  logic          bit_i,
  input  logic [WB-1:0] b_i,
  output logic [WB:0]   r_o,
  output logic          q_o
);

  logic [WB:0] t;
  logic        unused_r_msb;

  // The partial remainder MSB is always shifted out; only the low WB bits carry forward.
  assign unused_r_msb = r_i[WB];
  assign t            = {r_i[WB-1:0], bit_i};
  assign q_o          = (t >= {1'b0, b_i});
  assign r_o          = q_o ? (t - {1'b0, b_i}) : t;

endmodule

// File: rtl/div.sv
// Sequential unsigned restoring divider, one quotient bit per clock, start/fin handshake.
// Optional feature macro DIV_DZ_EN: adds the dz port and a one-cycle divide-by-zero shortcut.
module div import div_pkg::*; #(
  parameter int unsigned WA = DIV_WA,
  parameter int unsigned WB = DIV_WB
) (
  input  logic          ck,
  input  logic          rst_n,
  input  logic          start,
  input  logic [WA-1:0] A,
  input  logic [WB-1:0] B,
  output logic [WA-1:0] Q,
  output logic [WB-1:0] R,
  output logic          fin,
  output logic          busy
`ifdef DIV_DZ_EN
  ,
  output logic          dz
`endif
);

  localparam int unsigned     CntW    = div_cnt_w(WA);
  localparam logic [CntW-1:0] LastCnt = CntW'(WA - 1);

  div_state_e      state_q, state_d;
  logic [WA-1:0]   a_sh_q, a_sh_d;
  logic [WB-1:0]   b_r_q, b_r_d;
  logic [WB:0]     r_q, r_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [WA-1:0]   q_q, q_d;
  logic [WB-1:0]   rem_q, rem_d;
  logic            fin_q, fin_d;
`ifdef DIV_DZ_EN
  logic            dz_q, dz_d;
`endif

  logic [WB:0] r_nxt;
  logic        q_bit;

  div_step #(
    .WB (WB)
  ) u_step (
    .r_i   (r_q),
    .bit_i (a_sh_q[WA-1]),
    .b_i   (b_r_q),
    .r_o   (r_nxt),
    .q_o   (q_bit)
  );

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_r_d   = b_r_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    rem_d   = rem_q;
    fin_d   = 1'b0;
`ifdef DIV_DZ_EN
    dz_d    = dz_q;
`endif
    case (state_q)
      StIdle: begin
        if (start) begin
          a_sh_d  = A;
          b_r_d   = B;
          r_d     = '0;
          cnt_d   = '0;
          state_d = StCalc;
        end
      end
      StCalc: begin
`ifdef DIV_DZ_EN
        if (b_r_q == '0) begin
          // Same Q/R the full iteration would give, without spending WA cycles.
          q_d     = '1;
          rem_d   = a_sh_q[WB-1:0];
          dz_d    = 1'b1;
          fin_d   = 1'b1;
          state_d = StIdle;
        end else
`endif
        begin
          a_sh_d = {a_sh_q[WA-2:0], q_bit};
          r_d    = r_nxt;
          cnt_d  = cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            q_d     = {a_sh_q[WA-2:0], q_bit};
            rem_d   = r_nxt[WB-1:0];
            fin_d   = 1'b1;
            state_d = StIdle;
`ifdef DIV_DZ_EN
            dz_d    = 1'b0;
`endif
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_sh_q  <= '0;
      b_r_q   <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      rem_q   <= '0;
      fin_q   <= 1'b0;
`ifdef DIV_DZ_EN
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_r_q   <= b_r_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      rem_q   <= rem_d;
      fin_q   <= fin_d;
`ifdef DIV_DZ_EN
      dz_q    <= dz_d;
`endif
    end
  end

  assign Q    = q_q;
  assign R    = rem_q;
  assign fin  = fin_q;
  assign busy = (state_q == StCalc);
`ifdef DIV_DZ_EN
  assign dz   = dz_q;
`endif

endmodule

// File: tb/tb_div.sv
// Scoreboard bench for div: driver pushes expected results, monitor checks busy/fin timing and Q/R.
module tb_div;

  localparam int unsigned WA = 16;
  localparam int unsigned WB = 8;

  logic          ck;
  logic          rst_n;
  logic          start;
  logic [WA-1:0] A;
  logic [WB-1:0] B;
  logic [WA-1:0] Q;
  logic [WB-1:0] R;
  logic          fin;
  logic          busy;
`ifdef DIV_DZ_EN
  logic          dz;
`endif

  div #(
    .WA (WA),
    .WB (WB)
  ) dut (
    .ck    (ck),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .Q     (Q),
    .R     (R),
    .fin   (fin),
    .busy  (busy)
`ifdef DIV_DZ_EN
    ,
    .dz    (dz)
`endif
  );

  typedef struct packed {
    logic [WA-1:0] q;
    logic [WB-1:0] r;
    logic          dz;
  } exp_t;

  exp_t sb[$];

  int cyc       = 0;
  int last_acc  = -100;
  int last_lat  = 0;
  int free_edge = 0;
  int n_acc     = 0;
  int n_cmp     = 0;
  int n_bad     = 0;

  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  always @(posedge ck) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer division, with the documented divide-by-zero result.
  task automatic drive_cycle(input logic s, input logic [WA-1:0] a, input logic [WB-1:0] b);
    exp_t e;
    int   lat;
    int   edge_n;
    @(negedge ck);
    start = s;
    A     = a;
    B     = b;
    edge_n = cyc + 1;
    if (s && rst_n && edge_n >= free_edge) begin
      if (b == '0) begin
        e.q = '1;
        e.r = a[WB-1:0];
      end else begin
        e.q = a / WA'(b);
        e.r = WB'(a % WA'(b));
      end
      lat = WA;
      e.dz = 1'b0;
`ifdef DIV_DZ_EN
      if (b == '0) begin
        lat  = 1;
        e.dz = 1'b1;
      end
`endif
      sb.push_back(e);
      last_acc  = edge_n;
      last_lat  = lat;
      free_edge = edge_n + lat + 1;
      n_acc++;
    end
  endtask

  task automatic wait_idle();
    while (cyc < free_edge) drive_cycle(1'b0, '0, '0);
  endtask

  task automatic do_op(input logic [WA-1:0] a, input logic [WB-1:0] b);
    drive_cycle(1'b1, a, b);
    wait_idle();
  endtask

  task automatic do_reset(input string tag);
    @(negedge ck);
    rst_n = 1'b0;
    start = 1'b0;
    sb.delete();
    last_acc  = -100;
    last_lat  = 0;
    free_edge = 0;
    #1;
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_fin"},  32'(fin),  32'd0);
    check({tag, "_q"},    32'(Q),    32'd0);
    check({tag, "_r"},    32'(R),    32'd0);
`ifdef DIV_DZ_EN
    check({tag, "_dz"},   32'(dz),   32'd0);
`endif
    @(negedge ck);
    rst_n = 1'b1;
  endtask

  // Monitor: exact busy/fin timing from the model, result popped on every fin.
  initial begin
    exp_t e;
    logic exp_busy;
    logic exp_fin;
    forever begin
      @(posedge ck);
      #1;
      exp_busy = (cyc >= last_acc) && (cyc < last_acc + last_lat);
      exp_fin  = (cyc == last_acc + last_lat);
      check("busy", 32'(busy), 32'(exp_busy));
      check("fin",  32'(fin),  32'(exp_fin));
      if (fin) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL fin_unexpected: got fin=1 with no operation pending (edge %0d)", cyc);
        end else begin
          e = sb.pop_front();
          check("quotient",  32'(Q), 32'(e.q));
          check("remainder", 32'(R), 32'(e.r));
`ifdef DIV_DZ_EN
          check("dz", 32'(dz), 32'(e.dz));
`endif
        end
      end
    end
  end

  initial begin
    int guard;
    rst_n = 1'b0;
    start = 1'b0;
    A     = '0;
    B     = '0;
    do_reset("reset");

    do_op(16'd1000, 8'd7);
    do_op(16'hFFFF, 8'hFF);
    do_op(16'd5, 8'd9);
    do_op(16'h1234, 8'd0);

    // Start pulsed mid-run must be ignored.
    drive_cycle(1'b1, 16'd1000, 8'd7);
    repeat (3) drive_cycle(1'b0, '0, '0);
    drive_cycle(1'b1, 16'd50, 8'd3);
    wait_idle();

    // Reset at cycle 8 of a run aborts it.
    drive_cycle(1'b1, 16'd1000, 8'd7);
    repeat (6) drive_cycle(1'b0, '0, '0);
    do_reset("abort");
    repeat (20) drive_cycle(1'b0, '0, '0);
    do_op(16'd100, 8'd10);

    // Back-to-back with start held high; operands change every cycle.
    n_acc = 0;
    guard = 0;
    while (n_acc < 200 && guard < 10000) begin
      drive_cycle(1'b1, WA'($urandom), WB'($urandom));
      guard++;
    end
    check("b2b_count", 32'(n_acc), 32'd200);
    wait_idle();
    repeat (3) drive_cycle(1'b0, '0, '0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/div.md
# div

Sequential unsigned restoring divider: the inverse companion of the team's `mul` shift-add multiplier. It uses the same `start`/`fin` handshake, so benches and controllers that drive `mul` can drive `div` unchanged. The divider takes a WA-bit dividend and a WB-bit divisor and produces one quotient bit per clock. It sits beside `mul` in the arithmetic datapath and is driven by a controller that changes inputs on the falling edge of `ck`.

## Interface
- `WA`, 16, dividend and quotient width
- `WB`, 8, divisor and remainder width (WB ≤ WA)
- `ck`  in  1  clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  request; sampled only while `busy`=0
- `A`  in  WA  dividend; sampled on the accepting edge
- `B`  in  WB  divisor; sampled on the accepting edge
- `Q`  out  WA  quotient; registered, held until the next completion
- `R`  out  WB  remainder; registered, held until the next completion
- `fin`  out  1  one-cycle pulse: `Q`/`R` are updated and valid
- `busy`  out  1  high from acceptance through the last iteration
- `dz`  out  1  divide-by-zero flag for the last result (present only with `DIV_DZ_EN`)

## Operation
- States: IDLE, CALC.
  - IDLE, `start`=1 → latch `A` into the shift register `a_sh` and `B` into `b_r`; clear the partial remainder `r` (WB+1 bits) and the counter `cnt`; go to CALC; `busy`=1.
  - CALC: each edge performs one iteration.
    - `t = {r[WB-1:0], a_sh[WA-1]}`
    - If `t ≥ b_r`: `r = t − b_r` and the quotient bit is 1.
    - Otherwise: `r = t` and the quotient bit is 0.
    - The quotient bit is shifted into the LSB of `a_sh`.
    - `cnt` increments.
  - After WA iterations: `Q ← a_sh`, `R ← r[WB-1:0]`, `fin` ← 1, `busy` ← 0, back to IDLE.
- All arithmetic is unsigned. The comparison is done at WB+1 bits, so there is no overflow, and every result satisfies `A == Q*B + R` with `R < B` (for `B` ≠ 0).
- `start` while `busy`=1 is ignored; the operation in flight is unaffected.
- `start` in the same cycle that `fin` is high is accepted, because `busy` is already 0.
- Divide by zero produces `Q` = all ones and `R` = `A[WB-1:0]`. This is the natural restoring-algorithm result; see Configuration for latency and the flag.
- Reset values: `Q`=0, `R`=0, `fin`=0, `busy`=0, `dz`=0; state IDLE.
- Reset mid-operation aborts the division immediately: no `fin`, and outputs go to their reset values.

## Timing
- Accepting edge k: `busy` rises at k.
- Iterations occur at edges k+1 … k+WA.
- At edge k+WA: `Q`/`R` are updated, `fin`=1, `busy`=0.
- At edge k+WA+1: `fin`=0.
- Latency: WA cycles from acceptance to `fin`.
- Throughput: one division every WA+1 cycles if `start` is held high.
- `fin` is never high for two consecutive cycles.

## Configuration
- `DIV_DZ_EN` defined:
  - The `dz` port exists.
  - `B`=0 on acceptance skips CALC: at edge k+1, `Q` = all ones, `R` = `A[WB-1:0]`, `dz`=1, `fin`=1.
  - `dz` is updated with every `fin`, and is 0 for nonzero divisors.
- `DIV_DZ_EN` undefined:
  - No `dz` port.
  - `B`=0 runs the full WA iterations and yields the same `Q`/`R` values.

## Structure
- Package `div_pkg`:
  - state enum (IDLE, CALC)
  - default widths `DIV_WA`=16, `DIV_WB`=8
  - counter width `$clog2(WA+1)`
- Sub-module `div_step`: combinational single iteration.
  - Inputs: `r`, incoming bit, `b`.
  - Outputs: next `r`, quotient bit.
  - `div` instantiates it once and iterates over it in time.

## Test plan
- `A`=1000, `B`=7 → `Q`=142, `R`=6; `fin` exactly 16 cycles after acceptance; `busy` high for 16 cycles.
- `A`=0xFFFF, `B`=0xFF → `Q`=0x0101, `R`=0. Then `A`=5, `B`=9 → `Q`=0, `R`=5.
- `A`=0x1234, `B`=0:
  - With `DIV_DZ_EN`: `fin` after 1 cycle, `dz`=1, `Q`=0xFFFF, `R`=0x34.
  - Without `DIV_DZ_EN`: `fin` after 16 cycles, same `Q`/`R`.
- Second `start` (`A`=50, `B`=3) pulsed 4 cycles into a 1000/7 run → ignored; the result is still 142/6, followed by exactly one `fin`.
- `rst_n` low at cycle 8 of a run → `busy`, `fin`, `Q`, `R` all 0; no `fin` afterwards. The next `start` (`A`=100, `B`=10) gives `Q`=10, `R`=0.
- 200 back-to-back `$random` operands, with `start` held high → every `fin` satisfies `A == Q*B + R` and `R < B`; `fin` spacing is 17 cycles.
